// File: rtl/cpu_pkg.sv
// cpu_pkg: shared word width, divide-by-zero quotient and divider state encoding.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  // Quotient reported when the divisor is zero.
  localparam logic [WORD_W-1:0] DIV_ZERO_QUOT = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration. Shifts {rem, dq} left by one,
// trial-subtracts the divisor magnitude and shifts the quotient bit into dq.
module div_step
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_dq,
  input  logic [WIDTH-1:0] i_dsr,
  output logic [WIDTH-1:0] o_rem_c,
  output logic [WIDTH-1:0] o_dq_c
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_take;

  // Shift, trial-subtract in WIDTH+1 bits, keep or restore.
  always_comb begin
    w_shift = {i_rem, i_dq[WIDTH-1]};
    w_diff  = w_shift - {1'b0, i_dsr};
    w_take  = ~w_diff[WIDTH];
    o_rem_c = w_take ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    o_dq_c  = {i_dq[WIDTH-2:0], w_take};
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle signed radix-2 restoring divider for DIV.
// Quotient goes to LO, remainder to HI; z_out = {remainder, quotient}.
// Optional macro SEQ_DIV_EARLY_EXIT_EN: skip the iteration loop when the
// divisor is zero or |dividend| < |divisor|.
module seq_divider
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = WORD_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_zero,
  output logic [2*WIDTH-1:0] z_out
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_e       r_state;
  div_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_dvd_in;
  logic [WIDTH-1:0] r_dsr_in;
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_dsr_mag;
  logic [WIDTH-1:0] r_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_busy;
  logic             r_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic [2*WIDTH-1:0] r_z_out;

  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;
  logic [WIDTH-1:0] w_rem_nxt;
  logic [WIDTH-1:0] w_dq_nxt;
  logic [WIDTH-1:0] w_quo_fix;
  logic [WIDTH-1:0] w_rem_fix;
  logic             w_dsr_zero;
`ifdef SEQ_DIV_EARLY_EXIT_EN
  logic             r_early;
  logic             w_early;
`endif

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem   (r_rem),
    .i_dq    (r_dq),
    .i_dsr   (r_dsr_mag),
    .o_rem_c (w_rem_nxt),
    .o_dq_c  (w_dq_nxt)
  );

  // Operand magnitudes and sign-corrected results.
  always_comb begin
    w_dvd_mag  = r_dvd_in[WIDTH-1] ? WIDTH'(-r_dvd_in) : r_dvd_in;
    w_dsr_mag  = r_dsr_in[WIDTH-1] ? WIDTH'(-r_dsr_in) : r_dsr_in;
    w_dsr_zero = (r_dsr_mag == '0);
    w_quo_fix  = r_sign_q ? WIDTH'(-r_dq) : r_dq;
    if (w_dsr_zero) w_quo_fix = WIDTH'($signed(DIV_ZERO_QUOT));
    w_rem_fix  = r_sign_r ? WIDTH'(-r_rem) : r_rem;
`ifdef SEQ_DIV_EARLY_EXIT_EN
    w_early    = (w_dsr_mag == '0) || (w_dvd_mag < w_dsr_mag);
`endif
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (start) w_state_nxt = PREP;
`ifdef SEQ_DIV_EARLY_EXIT_EN
      PREP: w_state_nxt = w_early ? DONE : CALC;
`else
      PREP: w_state_nxt = CALC;
`endif
      CALC: if (r_cnt == '0) w_state_nxt = FIX;
      FIX:  w_state_nxt = DONE;
`ifdef SEQ_DIV_EARLY_EXIT_EN
      DONE: w_state_nxt = r_early ? DONE : IDLE;
`else
      DONE: w_state_nxt = IDLE;
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dvd_in    <= '0;
      r_dsr_in    <= '0;
      r_dq        <= '0;
      r_dsr_mag   <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_z_out     <= '0;
`ifdef SEQ_DIV_EARLY_EXIT_EN
      r_early     <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd_in <= dividend;
            r_dsr_in <= divisor;
            r_busy   <= 1'b1;
          end
        end
        PREP: begin
          r_dq      <= w_dvd_mag;
          r_dsr_mag <= w_dsr_mag;
          r_sign_q  <= r_dvd_in[WIDTH-1] ^ r_dsr_in[WIDTH-1];
          r_sign_r  <= r_dvd_in[WIDTH-1];
          r_rem     <= '0;
          r_cnt     <= CNT_W'(WIDTH - 1);
`ifdef SEQ_DIV_EARLY_EXIT_EN
          r_early   <= w_early;
`endif
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_dq  <= w_dq_nxt;
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          r_quotient  <= w_quo_fix;
          r_remainder <= w_rem_fix;
          r_z_out     <= {w_rem_fix, w_quo_fix};
          r_div_zero  <= w_dsr_zero;
          r_done      <= 1'b1;
        end
        DONE: begin
`ifdef SEQ_DIV_EARLY_EXIT_EN
          // Early exit publishes its short-cut result one cycle into DONE.
          if (r_early) begin
            r_early     <= 1'b0;
            r_quotient  <= w_dsr_zero ? WIDTH'($signed(DIV_ZERO_QUOT)) : '0;
            r_remainder <= r_dvd_in;
            r_z_out     <= {r_dvd_in,
                            (w_dsr_zero ? WIDTH'($signed(DIV_ZERO_QUOT)) : WIDTH'(0))};
            r_div_zero  <= w_dsr_zero;
            r_done      <= 1'b1;
          end else begin
            r_done <= 1'b0;
            r_busy <= 1'b0;
          end
`else
          r_done <= 1'b0;
          r_busy <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign div_zero  = r_div_zero;
  assign z_out     = r_z_out;

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle signed radix-2 divider. It sits directly downstream of the datapath's operand bus and Y register, and feeds the Z register.
- Produces quotient (to LO via Zlow) and remainder (to HI via Zhigh) for the DIV instruction.
- Replaces a single-cycle combinational divide so the datapath clock is not limited by a 32-step subtract chain.
- The control unit holds the DIV phase until done.

Parameters:
WIDTH, 32, operand/result width in bits

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  signed dividend (Y register value)
divisor  input  WIDTH  signed divisor (bus value)
busy  output  1  high from the accepting edge until done deasserts
done  output  1  one-cycle pulse; results valid
quotient  output  WIDTH  signed quotient, held until next accepted start
remainder  output  WIDTH  signed remainder, held until next accepted start
div_zero  output  1  divisor was zero; held with results
z_out  output  2*WIDTH  {remainder, quotient}, for Zhigh/Zlow

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE.
  - busy, done, div_zero, quotient, remainder, z_out all = 0.
  - Reset mid-operation aborts the operation; no done pulse is produced.
- States: IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- IDLE: start=1 at edge k captures dividend and divisor, goes to PREP, busy=1. start=0 stays in IDLE.
- PREP, edge k+1:
  - Register magnitudes |dividend| and |divisor|.
  - Register sign_q = sign(dividend) XOR sign(divisor), and sign_r = sign(dividend).
  - Clear the partial remainder, load the iteration counter with WIDTH-1, go to CALC.
- CALC, edges k+2 .. k+WIDTH+1: one restoring step per edge.
  - Shift {partial remainder, dividend magnitude} left by 1.
  - Trial-subtract the divisor magnitude in WIDTH+1 bits.
  - If the result is non-negative, keep it and shift a 1 into the quotient; else restore and shift a 0.
  - Go to FIX when the counter reaches 0.
- FIX, edge k+WIDTH+2:
  - Negate the quotient if sign_q; negate the remainder if sign_r.
  - Register quotient, remainder and z_out; done=1; go to DONE.
- DONE: done=0 and busy=0 at the next edge, return to IDLE. Latency is WIDTH+2 edges from acceptance to done (34 at WIDTH=32).
- Arithmetic rules:
  - Truncating division: the quotient rounds toward zero and the remainder takes the dividend's sign.
  - Invariant: dividend = quotient*divisor + remainder.
  - MIN / -1 wraps: quotient = 0x80000000, remainder = 0, div_zero = 0.
- Divisor = 0: quotient = all ones, remainder = dividend, div_zero = 1. Latency is unchanged unless the early-exit feature applies.
- Simultaneous events:
  - start while busy is ignored and does not queue.
  - start in the DONE cycle is ignored; it is accepted from IDLE only.
  - Operand changes after acceptance have no effect.

Optional Feature:
SEQ_DIV_EARLY_EXIT_EN
- Defined: in PREP, if divisor==0 or |dividend| < |divisor|, skip CALC and FIX and go straight to DONE. Results:
  - quotient = 0 (or all ones when div_zero);
  - remainder = dividend;
  - done asserted after edge k+2.
- Undefined: latency is always WIDTH+2, including divide by zero; results are identical.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum: IDLE, PREP, CALC, FIX, DONE;
  - the WORD_W=32 constant;
  - the DIV_ZERO_QUOT all-ones constant.
- One natural sub-module: div_step, a combinational shift/trial-subtract of one iteration. It is instantiated once inside the CALC register loop.

Test Plan:
- Result values:
  - 0x22 / 0x24 -> quotient 0x00000000, remainder 0x00000022, done at edge 34 after accept (edge 2 with EARLY_EXIT_EN).
  - 100 / 7 -> quotient 0x0000000E, remainder 0x00000002; z_out = 0x00000002_0000000E.
  - -100 / 7 -> quotient 0xFFFFFFF2, remainder 0xFFFFFFFE; 100 / -7 -> quotient 0xFFFFFFF2, remainder 0x00000002.
- Boundary cases:
  - 0x12345678 / 0 -> div_zero=1, quotient 0xFFFFFFFF, remainder 0x12345678.
  - 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, div_zero=0.
- Reset and handshake:
  - Reset low at CALC edge 10 -> all outputs 0, IDLE, no done pulse; a following start of 9/2 -> quotient 4, remainder 1.
  - start pulsed again while busy with new operands -> ignored; the original result is produced and exactly one done pulse occurs.
